// File: rtl/pc_fetch.sv
// Instruction-fetch front end: owns the PC, drives the instruction-memory address
// and captures the returned word into the IF/ID register.
module pc_fetch #(
    parameter logic [63:0] RESET_PC = 64'h0,
    parameter int          CNT_W    = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             stall,
    input  logic             br_taken,
    input  logic [63:0]      br_base,
    input  logic [63:0]      br_offs,
    output logic [63:0]      imem_addr,
    input  logic [31:0]      imem_rdata,
    output logic [63:0]      if_pc,
    output logic [31:0]      if_instr,
    output logic             if_valid,
    output logic [CNT_W-1:0] fetch_cnt
);

    typedef enum logic [1:0] {
        ACT_RESET,
        ACT_REDIRECT,
        ACT_HOLD,
        ACT_RUN
    } action_t;

    logic [63:0] pc;
    logic [63:0] tgt;
    action_t     action;

    // Offset counts instructions; the shift and add both wrap mod 2^64.
    assign tgt       = br_base + (br_offs << 2);
    assign imem_addr = pc;

    // Priority decode: reset beats redirect, redirect beats stall.
    always_comb begin
        action = ACT_RUN;
        if (reset)
            action = ACT_RESET;
        else if (br_taken)
            action = ACT_REDIRECT;
        else if (stall)
            action = ACT_HOLD;
    end

    // NOTE: non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        case (action)
            ACT_RESET: begin
                pc        <= RESET_PC;
                if_pc     <= 64'h0;
                if_instr  <= 32'h0;
                if_valid  <= 1'b0;
                fetch_cnt <= '0;
            end
            ACT_REDIRECT: begin
                // The word fetched this cycle is wrong-path, so squash it.
                pc       <= tgt;
                if_valid <= 1'b0;
            end
            ACT_HOLD: begin
            end
            default: begin
                pc        <= pc + 64'd4;
                if_pc     <= pc;
                if_instr  <= imem_rdata;
                if_valid  <= 1'b1;
                fetch_cnt <= fetch_cnt + CNT_W'(1);
            end
        endcase
    end

endmodule

// File: tb/tb_pc_fetch.sv
// Directed bench for pc_fetch: a vector table for the main stream, plus
// hand-written sequences for mid-stall reset, PC wrap and counter wrap.
module tb_pc_fetch;

    logic        clk = 1'b0;
    logic        reset, stall, br_taken;
    logic [63:0] br_base, br_offs;
    logic [63:0] imem_addr, if_pc;
    logic [31:0] imem_rdata, if_instr;
    logic        if_valid;
    logic [31:0] fetch_cnt;

    logic        reset1;
    logic [63:0] imem_addr1, if_pc1;
    logic [31:0] imem_rdata1, if_instr1;
    logic        if_valid1;
    logic [1:0]  fetch_cnt1;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    function automatic logic [31:0] mem_word(input logic [63:0] a);
        return a[31:0] ^ 32'hC0DE_0000;
    endfunction

    assign imem_rdata  = mem_word(imem_addr);
    assign imem_rdata1 = mem_word(imem_addr1);

    pc_fetch #(.RESET_PC(64'h0), .CNT_W(32)) dut (
        .clk(clk), .reset(reset), .stall(stall), .br_taken(br_taken),
        .br_base(br_base), .br_offs(br_offs), .imem_addr(imem_addr),
        .imem_rdata(imem_rdata), .if_pc(if_pc), .if_instr(if_instr),
        .if_valid(if_valid), .fetch_cnt(fetch_cnt)
    );

    pc_fetch #(.RESET_PC(64'hFFFF_FFFF_FFFF_FFF8), .CNT_W(2)) dut_wrap (
        .clk(clk), .reset(reset1), .stall(1'b0), .br_taken(1'b0),
        .br_base(64'h0), .br_offs(64'h0), .imem_addr(imem_addr1),
        .imem_rdata(imem_rdata1), .if_pc(if_pc1), .if_instr(if_instr1),
        .if_valid(if_valid1), .fetch_cnt(fetch_cnt1)
    );

    typedef struct {
        logic        rst;
        logic        stl;
        logic        br;
        logic [63:0] base;
        logic [63:0] offs;
        logic [63:0] addr;
        logic [63:0] ifpc;
        logic        valid;
        logic [31:0] cnt;
        logic        instr_zero;
    } vec_t;

    localparam int NVEC = 19;
    vec_t vecs[NVEC];

    function automatic vec_t mkv(input logic rst, input logic stl, input logic br,
                                 input logic [63:0] base, input logic [63:0] offs,
                                 input logic [63:0] addr, input logic [63:0] ifpc,
                                 input logic valid, input logic [31:0] cnt,
                                 input logic instr_zero);
        vec_t v;
        v.rst = rst; v.stl = stl; v.br = br; v.base = base; v.offs = offs;
        v.addr = addr; v.ifpc = ifpc; v.valid = valid; v.cnt = cnt;
        v.instr_zero = instr_zero;
        return v;
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic drive(input logic rst, input logic stl, input logic br,
                         input logic [63:0] base, input logic [63:0] offs);
        @(negedge clk);
        reset = rst; stall = stl; br_taken = br; br_base = base; br_offs = offs;
        @(posedge clk);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        reset = 1'b1; stall = 1'b0; br_taken = 1'b0;
        br_base = 64'h0; br_offs = 64'h0; reset1 = 1'b1;

        //              rst  stl  br   base    offs                    addr    ifpc    v    cnt  iz
        vecs[0]  = mkv(1'b1,1'b0,1'b0,64'h0,  64'h0,                  64'h0,  64'h0,  1'b0, 0, 1'b1);
        vecs[1]  = mkv(1'b0,1'b0,1'b0,64'h0,  64'h0,                  64'h4,  64'h0,  1'b1, 1, 1'b0);
        vecs[2]  = mkv(1'b0,1'b0,1'b0,64'h0,  64'h0,                  64'h8,  64'h4,  1'b1, 2, 1'b0);
        vecs[3]  = mkv(1'b0,1'b0,1'b0,64'h0,  64'h0,                  64'hC,  64'h8,  1'b1, 3, 1'b0);
        vecs[4]  = mkv(1'b0,1'b0,1'b0,64'h0,  64'h0,                  64'h10, 64'hC,  1'b1, 4, 1'b0);
        vecs[5]  = mkv(1'b0,1'b1,1'b0,64'h0,  64'h0,                  64'h10, 64'hC,  1'b1, 4, 1'b0);
        vecs[6]  = mkv(1'b0,1'b1,1'b0,64'h0,  64'h0,                  64'h10, 64'hC,  1'b1, 4, 1'b0);
        vecs[7]  = mkv(1'b0,1'b1,1'b0,64'h0,  64'h0,                  64'h10, 64'hC,  1'b1, 4, 1'b0);
        vecs[8]  = mkv(1'b0,1'b0,1'b0,64'h0,  64'h0,                  64'h14, 64'h10, 1'b1, 5, 1'b0);
        vecs[9]  = mkv(1'b0,1'b0,1'b0,64'h0,  64'h0,                  64'h18, 64'h14, 1'b1, 6, 1'b0);
        vecs[10] = mkv(1'b0,1'b0,1'b1,64'h20, 64'h5,                  64'h34, 64'h14, 1'b0, 6, 1'b0);
        vecs[11] = mkv(1'b0,1'b0,1'b0,64'h0,  64'h0,                  64'h38, 64'h34, 1'b1, 7, 1'b0);
        vecs[12] = mkv(1'b0,1'b0,1'b1,64'h20, 64'hFFFF_FFFF_FFFF_FFFE,64'h18, 64'h34, 1'b0, 7, 1'b0);
        vecs[13] = mkv(1'b0,1'b1,1'b1,64'h100,64'h3,                  64'h10C,64'h34, 1'b0, 7, 1'b0);
        vecs[14] = mkv(1'b0,1'b1,1'b0,64'h0,  64'h0,                  64'h10C,64'h34, 1'b0, 7, 1'b0);
        vecs[15] = mkv(1'b0,1'b0,1'b0,64'h0,  64'h0,                  64'h110,64'h10C,1'b1, 8, 1'b0);
        vecs[16] = mkv(1'b0,1'b0,1'b0,64'h0,  64'h0,                  64'h114,64'h110,1'b1, 9, 1'b0);
        vecs[17] = mkv(1'b0,1'b0,1'b1,64'h10, 64'h4000_0000_0000_0001,64'h14, 64'h110,1'b0, 9, 1'b0);
        vecs[18] = mkv(1'b0,1'b0,1'b0,64'h0,  64'h0,                  64'h18, 64'h14, 1'b1, 10,1'b0);

        for (int i = 0; i < NVEC; i++) begin
            drive(vecs[i].rst, vecs[i].stl, vecs[i].br, vecs[i].base, vecs[i].offs);
            check($sformatf("v%0d imem_addr", i), imem_addr, vecs[i].addr);
            check($sformatf("v%0d if_pc", i), if_pc, vecs[i].ifpc);
            check($sformatf("v%0d if_valid", i), 64'(if_valid), 64'(vecs[i].valid));
            check($sformatf("v%0d fetch_cnt", i), 64'(fetch_cnt), 64'(vecs[i].cnt));
            check($sformatf("v%0d if_instr", i), 64'(if_instr),
                  vecs[i].instr_zero ? 64'h0 : 64'(mem_word(vecs[i].ifpc)));
        end

        // Reach pc = 0x40 with a valid instruction in IF/ID, stall, then reset
        // with stall and br_taken both high.
        drive(1'b0, 1'b0, 1'b1, 64'h3C, 64'h0);
        check("seq redirect addr", imem_addr, 64'h3C);
        drive(1'b0, 1'b0, 1'b0, 64'h0, 64'h0);
        check("seq run addr", imem_addr, 64'h40);
        check("seq run if_pc", if_pc, 64'h3C);
        check("seq run valid", 64'(if_valid), 64'h1);
        check("seq run cnt", 64'(fetch_cnt), 64'd11);
        drive(1'b0, 1'b1, 1'b0, 64'h0, 64'h0);
        check("seq stall addr", imem_addr, 64'h40);
        check("seq stall valid", 64'(if_valid), 64'h1);
        drive(1'b1, 1'b1, 1'b1, 64'h200, 64'h8);
        check("seq reset addr", imem_addr, 64'h0);
        check("seq reset valid", 64'(if_valid), 64'h0);
        check("seq reset cnt", 64'(fetch_cnt), 64'h0);
        check("seq reset if_pc", if_pc, 64'h0);
        check("seq reset if_instr", 64'(if_instr), 64'h0);
        drive(1'b0, 1'b0, 1'b0, 64'h0, 64'h0);
        check("seq post-reset addr", imem_addr, 64'h4);
        check("seq post-reset if_pc", if_pc, 64'h0);
        check("seq post-reset cnt", 64'(fetch_cnt), 64'h1);

        // PC wrap and 2-bit counter wrap on the second instance.
        @(negedge clk);
        reset1 = 1'b1;
        @(posedge clk);
        #1;
        check("wrap reset addr", imem_addr1, 64'hFFFF_FFFF_FFFF_FFF8);
        check("wrap reset valid", 64'(if_valid1), 64'h0);
        @(negedge clk);
        reset1 = 1'b0;
        begin
            logic [63:0] exp_addr [4];
            logic [63:0] exp_ifpc [4];
            logic [1:0]  exp_cnt  [4];
            exp_addr = '{64'hFFFF_FFFF_FFFF_FFFC, 64'h0, 64'h4, 64'h8};
            exp_ifpc = '{64'hFFFF_FFFF_FFFF_FFF8, 64'hFFFF_FFFF_FFFF_FFFC, 64'h0, 64'h4};
            exp_cnt  = '{2'd1, 2'd2, 2'd3, 2'd0};
            for (int k = 0; k < 4; k++) begin
                @(posedge clk);
                #1;
                check($sformatf("wrap%0d addr", k), imem_addr1, exp_addr[k]);
                check($sformatf("wrap%0d if_pc", k), if_pc1, exp_ifpc[k]);
                check($sformatf("wrap%0d if_instr", k), 64'(if_instr1), 64'(mem_word(exp_ifpc[k])));
                check($sformatf("wrap%0d cnt", k), 64'(fetch_cnt1), 64'(exp_cnt[k]));
            end
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/pc_fetch.md
# pc_fetch

Instruction-fetch front end for the 64-bit LEGv8 pipeline. It owns the program counter, drives the instruction-memory address, and captures the returned instruction into the IF/ID pipeline register. It consumes the sequential next-PC (PC+4) and the branch-redirect request from the execute stage, and honours stall requests from hazard detection. Its outputs are the only source of instructions for the decode stage.

## Interface
- `RESET_PC`, default 64'h0: PC value loaded on reset.
- `CNT_W`, default 32: width of the fetch counter.

- `clk`  in  1  single clock; all state updates on rising edge.
- `reset`  in  1  synchronous, active-high reset.
- `stall`  in  1  hazard unit request: hold PC and IF/ID.
- `br_taken`  in  1  execute-stage redirect request, valid for one cycle.
- `br_base`  in  64  PC of the branching instruction.
- `br_offs`  in  64  sign-extended word offset (instruction count, not bytes).
- `imem_addr`  out  64  instruction memory address; equals the PC register.
- `imem_rdata`  in  32  instruction word; memory read is combinational, same cycle.
- `if_pc`  out  64  IF/ID register: PC of the captured instruction.
- `if_instr`  out  32  IF/ID register: captured instruction.
- `if_valid`  out  1  IF/ID register holds a real instruction (0 = bubble).
- `fetch_cnt`  out  CNT_W  number of instructions delivered to IF/ID since reset.

## Operation
- State: `pc` (64), `if_pc` (64), `if_instr` (32), `if_valid` (1), `fetch_cnt` (CNT_W). `imem_addr = pc` combinationally.
- Branch target: `tgt = br_base + (br_offs << 2)`, 64-bit, carries out of bit 63 discarded (mod 2^64). Sequential next-PC: `pc + 4`, mod 2^64.
- Priority per rising edge, highest first:
  - `reset`: pc <= RESET_PC; if_pc <= 0; if_instr <= 0; if_valid <= 0; fetch_cnt <= 0.
  - `br_taken` (stall ignored): pc <= tgt; if_valid <= 0 (squash the wrong-path instruction); if_pc and if_instr hold; fetch_cnt holds.
  - `stall`: all state holds, including if_valid.
  - Normal: if_pc <= pc; if_instr <= imem_rdata; if_valid <= 1; pc <= pc + 4; fetch_cnt <= fetch_cnt + 1, wrapping to 0 after all ones.
- Alignment is not checked. pc[1:0] is carried as computed. A RESET_PC with nonzero low bits propagates unchanged.
- There is no internal FSM beyond the implicit RUN/HOLD/REDIRECT choice above, which is re-evaluated every cycle. A redirect is complete in one cycle.

## Timing
- Reset values: imem_addr = RESET_PC, if_pc = 0, if_instr = 0, if_valid = 0, fetch_cnt = 0. These are visible in the cycle after the reset edge.
- Latency: an instruction at address A is presented on imem_addr in cycle n and appears on if_instr/if_pc with if_valid=1 in cycle n+1 (one register stage).
- Redirect: br_taken sampled at edge n. The target is on imem_addr after edge n. if_valid=0 in cycle n+1. The target instruction is in IF/ID after edge n+1.
- Back-to-back br_taken on consecutive edges: each one redirects, and if_valid stays 0.
- Stall of k cycles: imem_addr, if_* and fetch_cnt are frozen for k cycles. Fetch resumes at the held PC with no instruction lost or duplicated.
- Reset asserted mid-stream (including during stall or with br_taken high): reset wins on that edge, and the in-flight instruction is discarded.
- PC wrap: pc = 64'hFFFF_FFFF_FFFF_FFFC advances to 64'h0.

## Test plan
- Reset then run with no stall or branch: imem_addr steps 0, 4, 8, 12. if_pc lags by one cycle (0, 4, 8). if_valid rises in the cycle after the first fetch edge. fetch_cnt = 3 after 3 fetch edges.
- Stall held 3 cycles while pc = 0x10: imem_addr stays 0x10 and if_pc stays 0xC for 3 cycles. After release, if_pc = 0x10 next, then 0x14.
- Forward branch: br_taken with br_base = 0x20, br_offs = 5 gives imem_addr = 0x34 next cycle and if_valid = 0 for one cycle, then if_pc = 0x34. Backward branch: br_offs = -2 (all-ones ...FE) gives target 0x18.
- br_taken and stall asserted together: the branch wins, and imem_addr equals the target next cycle.
- Wrap: RESET_PC = 64'hFFFF_FFFF_FFFF_FFF8 gives imem_addr ...FFF8, ...FFFC, 0x0, 0x4.
- Reset asserted while stalled at pc = 0x40 with if_valid = 1: next cycle imem_addr = RESET_PC, if_valid = 0, fetch_cnt = 0.
